// File: rtl/dsp_data_mem_responder_if.sv
// Request/response bus between the DSP memory stage (master) and the
// data-memory/stack responder (slave). One request at a time, valid/ready
// on the request side, single-cycle response pulse with no back-pressure.
interface dsp_data_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_mode, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_mode, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dsp_data_mem_responder.sv
// Data-memory / hardware-stack responder for the DSP memory stage.
// Owns a synchronous-read RAM and the stack pointer; the stack lives in the
// top STACK_DEPTH words of RAM. Every request takes exactly two cycles from
// acceptance to the response pulse.
// Optional: define DSPMEM_BOUNDS_CHECK_EN to reject LD/ST into the stack region.
module dsp_data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int STACK_DEPTH = 16,
  parameter int STACK_BASE  = DEPTH - STACK_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  dsp_data_mem_responder_if.slave   bus,
  output logic [ADDR_W-1:0]         sp,
  output logic                      stack_full,
  output logic                      stack_empty
);

  localparam logic [2:0] M_NONE   = 3'd0;
  localparam logic [2:0] M_PUSH   = 3'd1;
  localparam logic [2:0] M_POP    = 3'd2;
  localparam logic [2:0] M_LD     = 3'd3;
  localparam logic [2:0] M_ST     = 3'd4;
  localparam logic [2:0] M_LD_IMM = 3'd5;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] SDEP_A = ADDR_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_ACK   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic              w_accept;
  state_t            w_target;
  logic              w_err, w_rd, w_push, w_pop, w_oob;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err, r_rd, r_push;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign stack_full  = (sp == SDEP_A);
  assign stack_empty = (sp == '0);

`ifdef DSPMEM_BOUNDS_CHECK_EN
  assign w_oob = (bus.req_addr >= BASE_A);
`else
  assign w_oob = 1'b0;
`endif

  // Decode the presented request: target state, RAM address, error and stack effects.
  always_comb begin
    w_target = S_ACK;
    w_err    = 1'b0;
    w_rd     = 1'b0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_addr   = bus.req_addr;
    unique case (bus.req_mode)
      M_PUSH: begin
        if (stack_full) w_err = 1'b1;
        else begin
          w_target = S_WRITE;
          w_push   = 1'b1;
          w_addr   = BASE_A + sp;
        end
      end
      M_POP: begin
        if (stack_empty) w_err = 1'b1;
        else begin
          w_target = S_READ;
          w_rd     = 1'b1;
          w_pop    = 1'b1;
          w_addr   = BASE_A + sp - 1'b1;
        end
      end
      M_LD: begin
        if (w_oob) w_err = 1'b1;
        else begin
          w_target = S_READ;
          w_rd     = 1'b1;
        end
      end
      M_ST: begin
        if (w_oob) w_err = 1'b1;
        else w_target = S_WRITE;
      end
      M_NONE, M_LD_IMM: ;
      default: w_err = 1'b1;
    endcase
  end

  // Next-state logic; RESP always returns to IDLE so no accept can overlap it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_target;
      S_READ,
      S_WRITE,
      S_ACK:   w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Capture the accepted request; inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_push  <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= w_addr;
      r_wdata <= bus.req_wdata;
      r_err   <= w_err;
      r_rd    <= w_rd;
      r_push  <= w_push;
    end
  end

  // Stack pointer: POP commits at accept, PUSH commits when the write lands.
  always_ff @(posedge clk) begin
    if (rst)                             sp <= '0;
    else if (w_accept && w_pop)          sp <= sp - 1'b1;
    else if (r_state == S_WRITE && r_push) sp <= sp + 1'b1;
  end

  // RAM: write in WRITE (suppressed under reset), registered read in READ.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_WRITE) mem[r_addr] <= r_wdata;
    if (r_state == S_READ)          r_ram_q     <= mem[r_addr];
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_err   = (r_state == S_RESP) && r_err;
  assign bus.rsp_data  = ((r_state == S_RESP) && r_rd) ? r_ram_q : '0;

endmodule

// File: tb/tb_dsp_data_mem_responder.sv
// Self-checking bench for dsp_data_mem_responder: directed scenarios plus a
// randomized request stream, all checked against a stack/array reference model.
module tb_dsp_data_mem_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sp;
  logic       stack_full, stack_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain RAM image with known-bits, stack occupancy as an int.
  logic [15:0] m_mem   [256];
  bit          m_known [256];
  int          m_sp;

  dsp_data_mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dsp_data_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Apply a request to the model; returns expected err/data and whether data is defined.
  task automatic model_req(input logic [2:0] mode, input logic [7:0] addr,
                           input logic [15:0] wd, output bit e,
                           output logic [15:0] d, output bit known);
    bit oob;
    oob = 1'b0;
`ifdef DSPMEM_BOUNDS_CHECK_EN
    oob = (addr >= 8'd240);
`endif
    e = 1'b0; d = 16'h0; known = 1'b1;
    case (mode)
      3'd1: if (m_sp == 16) e = 1'b1;
            else begin
              m_mem[240 + m_sp] = wd; m_known[240 + m_sp] = 1'b1; m_sp++;
            end
      3'd2: if (m_sp == 0) e = 1'b1;
            else begin
              m_sp--; d = m_mem[240 + m_sp]; known = m_known[240 + m_sp];
            end
      3'd3: if (oob) e = 1'b1;
            else begin d = m_mem[addr]; known = m_known[addr]; end
      3'd4: if (oob) e = 1'b1;
            else begin m_mem[addr] = wd; m_known[addr] = 1'b1; end
      3'd0, 3'd5: ;
      default: e = 1'b1;
    endcase
  endtask

  // Drive one request and observe its response; tim_ok reports the
  // accept/ready/rsp_valid pattern over the following three cycles.
  task automatic do_req(input logic [2:0] mode, input logic [7:0] addr,
                        input logic [15:0] wd, output bit e,
                        output logic [15:0] d, output bit tim_ok);
    int n;
    tim_ok = 1'b1; e = 1'b0; d = 16'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = mode;
    bus.req_addr  = addr; bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) tim_ok = 1'b0;
    @(negedge clk);                       // N+1
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) tim_ok = 1'b0;
    bus.req_mode  = 3'($urandom);          // junk while busy must be ignored
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 16'($urandom);
    @(negedge clk);                       // N+2
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) tim_ok = 1'b0;
    e = bus.rsp_err; d = bus.rsp_data;
    bus.req_valid = 1'b0;
    @(negedge clk);                       // N+3
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) tim_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = 1'b0; bus.req_mode = 3'd0;
    bus.req_addr = 8'h0; bus.req_wdata = 16'h0;
    m_sp = 0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
    n_tests++; if (bus.rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
    n_tests++; if (sp !== 8'd0) begin n_fail++; $display("FAIL reset_sp got %0d exp 0", sp); end
    n_tests++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", stack_empty, stack_full); end
  endtask

  task automatic test_st_ld();
    bit e, t, me, mk; logic [15:0] d, md;
    model_req(3'd4, 8'h10, 16'hBEEF, me, md, mk);
    do_req(3'd4, 8'h10, 16'hBEEF, e, d, t);
    n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL st_timing got %b exp 1", t); end
    n_tests++; if (e !== 1'b0 || d !== 16'h0) begin n_fail++; $display("FAIL st_ack got err=%b data=%h exp 0/0000", e, d); end
    model_req(3'd3, 8'h10, 16'h0, me, md, mk);
    do_req(3'd3, 8'h10, 16'h0, e, d, t);
    n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL ld_timing got %b exp 1", t); end
    n_tests++; if (e !== 1'b0 || d !== 16'hBEEF) begin n_fail++; $display("FAIL ld_data got err=%b data=%h exp 0/beef", e, d); end
  endtask

  task automatic test_push_full();
    bit e, t, me, mk; logic [15:0] d, md;
    for (int i = 1; i <= 16; i++) begin
      model_req(3'd1, 8'h0, 16'(i), me, md, mk);
      do_req(3'd1, 8'h0, 16'(i), e, d, t);
      n_tests++; if (e !== 1'b0 || t !== 1'b1) begin n_fail++; $display("FAIL push_%0d got err=%b tim=%b exp 0/1", i, e, t); end
    end
    n_tests++; if (sp !== 8'd16 || stack_full !== 1'b1) begin n_fail++; $display("FAIL full_sp got sp=%0d full=%b exp 16/1", sp, stack_full); end
    model_req(3'd1, 8'h0, 16'h1111, me, md, mk);
    do_req(3'd1, 8'h0, 16'h1111, e, d, t);
    n_tests++; if (e !== 1'b1 || d !== 16'h0) begin n_fail++; $display("FAIL push_overflow got err=%b data=%h exp 1/0000", e, d); end
    n_tests++; if (sp !== 8'd16) begin n_fail++; $display("FAIL overflow_sp got %0d exp 16", sp); end
  endtask

  task automatic test_pop_drain();
    bit e, t, me, mk; logic [15:0] d, md;
    for (int i = 16; i >= 1; i--) begin
      model_req(3'd2, 8'h0, 16'h0, me, md, mk);
      do_req(3'd2, 8'h0, 16'h0, e, d, t);
      n_tests++; if (e !== 1'b0 || d !== 16'(i) || t !== 1'b1) begin n_fail++; $display("FAIL pop_%0d got err=%b data=%h tim=%b exp 0/%h/1", i, e, d, t, 16'(i)); end
    end
    n_tests++; if (sp !== 8'd0 || stack_empty !== 1'b1) begin n_fail++; $display("FAIL drain_sp got sp=%0d empty=%b exp 0/1", sp, stack_empty); end
    model_req(3'd2, 8'h0, 16'h0, me, md, mk);
    do_req(3'd2, 8'h0, 16'h0, e, d, t);
    n_tests++; if (e !== 1'b1 || d !== 16'h0) begin n_fail++; $display("FAIL pop_underflow got err=%b data=%h exp 1/0000", e, d); end
    n_tests++; if (sp !== 8'd0) begin n_fail++; $display("FAIL underflow_sp got %0d exp 0", sp); end
  endtask

  task automatic test_illegal_none();
    bit e, t, me, mk; logic [15:0] d, md;
    logic [2:0] modes [4];
    bit         exp_e [4];
    modes[0] = 3'd6; exp_e[0] = 1'b1;
    modes[1] = 3'd7; exp_e[1] = 1'b1;
    modes[2] = 3'd0; exp_e[2] = 1'b0;
    modes[3] = 3'd5; exp_e[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_req(modes[i], 8'h10, 16'hDEAD, me, md, mk);
      do_req(modes[i], 8'h10, 16'hDEAD, e, d, t);
      n_tests++; if (e !== exp_e[i] || d !== 16'h0 || t !== 1'b1) begin n_fail++; $display("FAIL mode_%0d got err=%b data=%h tim=%b exp %b/0000/1", modes[i], e, d, t, exp_e[i]); end
    end
    n_tests++; if (sp !== 8'd0) begin n_fail++; $display("FAIL mode_sp got %0d exp 0", sp); end
    model_req(3'd3, 8'h10, 16'h0, me, md, mk);
    do_req(3'd3, 8'h10, 16'h0, e, d, t);
    n_tests++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL mode_ram got %h exp beef", d); end
  endtask

  task automatic test_reset_mid();
    bit e, t, me, mk; logic [15:0] d, md;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = 3'd1; bus.req_wdata = 16'hAAAA; bus.req_addr = 8'h0;
    @(negedge clk);                       // in WRITE
    bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_sp = 0;
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_tests++; if (sp !== 8'd0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state got sp=%0d ready=%b exp 0/1", sp, bus.req_ready); end
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rsp got %b exp 0", bus.rsp_valid); end
`ifndef DSPMEM_BOUNDS_CHECK_EN
    model_req(3'd3, 8'hF0, 16'h0, me, md, mk);
    do_req(3'd3, 8'hF0, 16'h0, e, d, t);
    n_tests++; if (d !== 16'h0001 || d !== md) begin n_fail++; $display("FAIL rstmid_mem240 got %h exp 0001", d); end
`else
    // With direct access blocked, the first PUSH after reset reads back slot 240.
    model_req(3'd1, 8'h0, 16'h7777, me, md, mk);
    do_req(3'd1, 8'h0, 16'h7777, e, d, t);
    model_req(3'd2, 8'h0, 16'h0, me, md, mk);
    do_req(3'd2, 8'h0, 16'h0, e, d, t);
    n_tests++; if (d !== 16'h7777) begin n_fail++; $display("FAIL rstmid_stack got %h exp 7777", d); end
`endif
  endtask

  task automatic test_bounds();
    bit e, t, me, mk; logic [15:0] d, md;
    model_req(3'd4, 8'hF0, 16'h5A5A, me, md, mk);
    do_req(3'd4, 8'hF0, 16'h5A5A, e, d, t);
    n_tests++; if (e !== me) begin n_fail++; $display("FAIL bounds_st got err=%b exp %b", e, me); end
    model_req(3'd3, 8'hF0, 16'h0, me, md, mk);
    do_req(3'd3, 8'hF0, 16'h0, e, d, t);
`ifdef DSPMEM_BOUNDS_CHECK_EN
    n_tests++; if (e !== 1'b1 || d !== 16'h0) begin n_fail++; $display("FAIL bounds_ld got err=%b data=%h exp 1/0000", e, d); end
`else
    n_tests++; if (e !== 1'b0 || d !== 16'h5A5A) begin n_fail++; $display("FAIL bounds_ld got err=%b data=%h exp 0/5a5a", e, d); end
`endif
  endtask

  task automatic test_random();
    bit e, t, me, mk; logic [15:0] d, md;
    logic [2:0] mode; logic [7:0] addr; logic [15:0] wd;
    for (int i = 0; i < 300; i++) begin
      mode = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 31));
      wd   = 16'($urandom);
      model_req(mode, addr, wd, me, md, mk);
      do_req(mode, addr, wd, e, d, t);
      n_tests++; if (t !== 1'b1 || e !== me || (mk && d !== md)) begin n_fail++; $display("FAIL rand_%0d mode=%0d addr=%h got err=%b data=%h tim=%b exp err=%b data=%h", i, mode, addr, e, d, t, me, md); end
      n_tests++; if (sp !== 8'(m_sp) || stack_full !== (m_sp == 16) || stack_empty !== (m_sp == 0)) begin n_fail++; $display("FAIL rand_sp_%0d got sp=%0d exp %0d", i, sp, m_sp); end
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_st_ld();
    test_push_full();
    test_pop_drain();
    test_illegal_none();
    test_push_full();
    test_pop_drain();
    test_reset_mid();
    test_bounds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
